// File: rtl/write_burst_sched_if.sv
// ----------------------------------------------------------------------------
// write_burst_sched_if
// Burst request handshake between the write burst scheduler and the AXI
// write master.
//   burst_req    : scheduler -> master, burst request (held until ack)
//   burst_len    : scheduler -> master, beats in the requested burst
//   burst_ack    : master -> scheduler, request accepted
//   burst_finish : master -> scheduler, 1-cycle pulse on last write response
// Modports:
//   master : scheduler side (drives the request)
//   slave  : AXI write master side (answers the request)
// ----------------------------------------------------------------------------
interface write_burst_sched_if #(
  parameter int LSIZE = 9
);
  logic             burst_req;
  logic [LSIZE-1:0] burst_len;
  logic             burst_ack;
  logic             burst_finish;

  modport master (
    output burst_req,
    output burst_len,
    input  burst_ack,
    input  burst_finish
  );

  modport slave (
    input  burst_req,
    input  burst_len,
    output burst_ack,
    output burst_finish
  );
endinterface

// File: rtl/write_burst_sched.sv
// ----------------------------------------------------------------------------
// write_burst_sched
// Schedules AXI write bursts for one video frame. On an enabled frame start it
// reloads the line-length summer, then repeatedly waits until the write FIFO
// holds a full burst (normal length or the summer's tail length), requests it
// from the AXI write master and reports completion back to the summer. The
// frame ends when the summer reports no beats outstanding.
//
// Ports:
//   clock        in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   enable       in   frame arming permitted
//   fsync        in   frame start pulse
//   fifo_count   in   AXI beats buffered in the write FIFO
//   tail_leave   in   frame still has beats outstanding
//   tail_status  in   next burst is the tail burst
//   tail_len     in   tail burst length
//   bus          --   burst request handshake (master modport)
//   burst_done   out  pulse: normal burst completed
//   tail_done    out  pulse: tail burst completed
//   frame_done   out  pulse: frame completed
//   frame_err    out  pulse: fsync arrived before frame completion
//   busy         out  state is not IDLE
//   burst_cnt    out  bursts completed in the current frame (saturating)
// ----------------------------------------------------------------------------
module write_burst_sched #(
  parameter int NOR_BURST_LEN = 200,
  parameter int LSIZE         = 9,
  parameter int FSIZE         = 12
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      fsync,
  input  logic [FSIZE-1:0]          fifo_count,
  input  logic                      tail_leave,
  input  logic                      tail_status,
  input  logic [LSIZE-1:0]          tail_len,
  write_burst_sched_if.master       bus,
  output logic                      burst_done,
  output logic                      tail_done,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      busy,
  output logic [15:0]               burst_cnt
);

  // Common width for the zero-extended FIFO level compare.
  localparam int CW = (FSIZE > LSIZE) ? FSIZE : LSIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_DATA,
    S_REQ,
    S_XFER,
    S_SETTLE,
    S_FRAME_END
  } state_t;

  state_t           r_state;
  logic             r_fsync_pend;
  logic             r_is_tail;
  logic             r_burst_req;
  logic [LSIZE-1:0] r_burst_len;
  logic             r_burst_done;
  logic             r_tail_done;
  logic             r_frame_done;
  logic             r_frame_err;
  logic             r_busy;
  logic [15:0]      r_burst_cnt;

  logic [LSIZE-1:0] w_sel_len;
  logic [CW-1:0]    w_fifo_ext;
  logic [CW-1:0]    w_sel_ext;
  logic             w_have_data;
  logic             w_tail_empty;

  assign w_sel_len    = tail_status ? tail_len : LSIZE'(NOR_BURST_LEN);
  assign w_fifo_ext   = CW'(fifo_count);
  assign w_sel_ext    = CW'(w_sel_len);
  assign w_have_data  = (w_fifo_ext >= w_sel_ext);
  assign w_tail_empty = tail_status && (tail_len == '0);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fsync_pend <= 1'b0;
      r_is_tail    <= 1'b0;
      r_burst_req  <= 1'b0;
      r_burst_len  <= '0;
      r_burst_done <= 1'b0;
      r_tail_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_cnt  <= '0;
    end else begin
      r_burst_done <= 1'b0;
      r_tail_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (fsync && enable) begin
            r_state     <= S_ARM;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
          end
        end

        // One-cycle summer reload; a further fsync simply restarts it.
        S_ARM: begin
          r_burst_cnt <= '0;
          r_busy      <= 1'b1;
          r_state     <= fsync ? S_ARM : S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          if (fsync) begin
            r_frame_err <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= S_ARM;
          end else if (!tail_leave) begin
            r_state <= S_FRAME_END;
          end else if (w_tail_empty) begin
            // Zero-length tail: report it to the summer without a bus request.
            r_tail_done <= 1'b1;
            r_state     <= S_SETTLE;
          end else if (w_have_data) begin
            r_burst_len <= w_sel_len;
            r_is_tail   <= tail_status;
            r_burst_req <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          if (fsync) begin
            r_fsync_pend <= 1'b1;
          end
          if (bus.burst_ack) begin
            r_burst_req <= 1'b0;
            r_state     <= S_XFER;
          end
        end

        // An fsync seen during the burst is deferred until the burst's last
        // response, then aborts the frame instead of reporting completion.
        S_XFER: begin
          if (bus.burst_finish) begin
            if (r_fsync_pend || fsync) begin
              r_frame_err  <= 1'b1;
              r_fsync_pend <= 1'b0;
              r_burst_cnt  <= '0;
              r_state      <= S_ARM;
            end else begin
              if (r_burst_cnt != 16'hFFFF) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
              end
              r_burst_done <= ~r_is_tail;
              r_tail_done  <= r_is_tail;
              r_state      <= S_SETTLE;
            end
          end else if (fsync) begin
            r_fsync_pend <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (fsync) begin
            r_frame_err <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= S_ARM;
          end else begin
            r_state <= S_WAIT_DATA;
          end
        end

        // frame_done is issued on the way out so a colliding fsync can
        // replace it with frame_err.
        S_FRAME_END: begin
          if (fsync) begin
            r_frame_err <= 1'b1;
            r_burst_cnt <= '0;
            r_state     <= S_ARM;
          end else begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_burst_req <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.burst_req = r_burst_req;
  assign bus.burst_len = r_burst_len;
  assign burst_done    = r_burst_done;
  assign tail_done     = r_tail_done;
  assign frame_done    = r_frame_done;
  assign frame_err     = r_frame_err;
  assign busy          = r_busy;
  assign burst_cnt     = r_burst_cnt;

endmodule

// File: tb/tb_write_burst_sched.sv
// ----------------------------------------------------------------------------
// tb_write_burst_sched
// Directed bench for write_burst_sched. Stimulus tasks describe frames as
// transactions (frame start, burst with given ack/finish delays, frame end)
// and derive the expected per-cycle outputs from the protocol timing; a
// compare process checks every output on each falling edge.
// ----------------------------------------------------------------------------
module tb_write_burst_sched;

  localparam int LSIZE = 9;
  localparam int FSIZE = 12;

  logic             clock = 1'b0;
  logic             rst;
  logic             enable;
  logic             fsync;
  logic [FSIZE-1:0] fifo_count;
  logic             tail_leave;
  logic             tail_status;
  logic [LSIZE-1:0] tail_len;
  logic             burst_done;
  logic             tail_done;
  logic             frame_done;
  logic             frame_err;
  logic             busy;
  logic [15:0]      burst_cnt;

  write_burst_sched_if #(.LSIZE(LSIZE)) bus ();

  write_burst_sched #(
    .NOR_BURST_LEN(200),
    .LSIZE        (LSIZE),
    .FSIZE        (FSIZE)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .fsync      (fsync),
    .fifo_count (fifo_count),
    .tail_leave (tail_leave),
    .tail_status(tail_status),
    .tail_len   (tail_len),
    .bus        (bus),
    .burst_done (burst_done),
    .tail_done  (tail_done),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .burst_cnt  (burst_cnt)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_req, e_bd, e_td, e_fd, e_fe, e_busy;
  int          m_cnt;
  int          m_len;

  // Transaction recorders.
  logic        rec_en = 1'b0;
  int          lens[$];
  int          n_bd = 0, n_td = 0, n_fd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("burst_req",  32'(bus.burst_req), 32'(e_req));
      chk("burst_len",  32'(bus.burst_len), 32'(m_len));
      chk("burst_done", 32'(burst_done),    32'(e_bd));
      chk("tail_done",  32'(tail_done),     32'(e_td));
      chk("frame_done", 32'(frame_done),    32'(e_fd));
      chk("frame_err",  32'(frame_err),     32'(e_fe));
      chk("busy",       32'(busy),          32'(e_busy));
      chk("burst_cnt",  32'(burst_cnt),     32'(m_cnt));
    end
  end

  always @(negedge clock) begin
    if (rec_en) begin
      if (bus.burst_req && bus.burst_ack) lens.push_back(int'(bus.burst_len));
      if (burst_done) n_bd++;
      if (tail_done)  n_td++;
      if (frame_done) n_fd++;
    end
  end

  // One cycle with the given expected outputs; returns just after the next edge.
  task automatic tick(input logic rq, input logic bd, input logic td,
                      input logic fd, input logic fe, input logic bs);
    e_req = rq; e_bd = bd; e_td = td; e_fd = fd; e_fe = fe; e_busy = bs;
    @(posedge clock);
    #1;
  endtask

  // From IDLE: fsync cycle, then ARM; returns with the WAIT_DATA cycle current.
  task automatic start_frame();
    fsync = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    fsync = 1'b0;
    m_cnt = 0;
    tick(0, 0, 0, 0, 0, 1);
  endtask

  // Current cycle is WAIT_DATA with data available. ackd = REQ cycles before
  // the ack cycle, find = XFER cycles including the finish cycle.
  task automatic do_burst(input int len, input logic tail, input int ackd, input int find);
    tick(0, 0, 0, 0, 0, 1);
    m_len = len;
    for (int i = 0; i <= ackd; i++) begin
      bus.burst_ack = (i == ackd);
      tick(1, 0, 0, 0, 0, 1);
    end
    bus.burst_ack = 1'b0;
    for (int j = 1; j <= find; j++) begin
      bus.burst_finish = (j == find);
      tick(0, 0, 0, 0, 0, 1);
    end
    bus.burst_finish = 1'b0;
    m_cnt = m_cnt + 1;
    tick(0, !tail, tail, 0, 0, 1);
  endtask

  // Current cycle is WAIT_DATA; ends the frame and returns in IDLE.
  task automatic end_frame();
    tail_leave = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 0);
    tail_leave = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; fsync = 1'b0; fifo_count = '0;
    tail_leave = 1'b1; tail_status = 1'b0; tail_len = '0;
    bus.burst_ack = 1'b0; bus.burst_finish = 1'b0;
    m_cnt = 0; m_len = 0;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, 0);

    // Two normal bursts and a 56-beat tail.
    enable = 1'b1; fifo_count = 12'd4095; rec_en = 1'b1;
    start_frame();
    do_burst(200, 0, 0, 10);
    do_burst(200, 0, 0, 10);
    tail_status = 1'b1; tail_len = 9'd56;
    do_burst(56, 1, 0, 10);
    tail_status = 1'b0;
    end_frame();
    rec_en = 1'b0;
    chk("n_lens",     32'(lens.size()), 32'd3);
    if (lens.size() == 3) begin
      chk("len0", 32'(lens[0]), 32'd200);
      chk("len1", 32'(lens[1]), 32'd200);
      chk("len2", 32'(lens[2]), 32'd56);
    end
    chk("n_burst_done", 32'(n_bd), 32'd2);
    chk("n_tail_done",  32'(n_td), 32'd1);
    chk("n_frame_done", 32'(n_fd), 32'd1);
    chk("frame_cnt",    32'(burst_cnt), 32'd3);

    // FIFO below the burst length, then refilled; slow ack on the second burst.
    fifo_count = 12'd150;
    start_frame();
    repeat (3) tick(0, 0, 0, 0, 0, 1);
    fifo_count = 12'd200;
    do_burst(200, 0, 0, 3);
    do_burst(200, 0, 5, 2);
    end_frame();
    chk("slow_ack_cnt", 32'(burst_cnt), 32'd2);

    // fsync during XFER: burst completes, then frame_err and re-arm.
    fifo_count = 12'd4095;
    start_frame();
    tick(0, 0, 0, 0, 0, 1);
    m_len = 200;
    bus.burst_ack = 1'b1;
    tick(1, 0, 0, 0, 0, 1);
    bus.burst_ack = 1'b0;
    fsync = 1'b1; enable = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    fsync = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    bus.burst_finish = 1'b1;
    tick(0, 0, 0, 0, 0, 1);
    bus.burst_finish = 1'b0;
    m_cnt = 0;
    tick(0, 0, 0, 0, 1, 1);
    end_frame();
    enable = 1'b1;

    // Zero-length tail, then reset while a request is pending.
    start_frame();
    tail_status = 1'b1; tail_len = '0;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 1);
    tail_status = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    m_len = 200;
    rst = 1'b1;
    tick(1, 0, 0, 0, 0, 1);
    rst = 1'b0;
    m_cnt = 0; m_len = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // fsync with enable low ignored; fsync in ARM restarts; fsync in WAIT_DATA errors.
    enable = 1'b0; fsync = 1'b1; fifo_count = '0;
    tick(0, 0, 0, 0, 0, 0);
    enable = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    m_cnt = 0;
    tick(0, 0, 0, 0, 0, 1);
    fsync = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    fsync = 1'b1;
    tick(0, 0, 0, 0, 0, 1);
    fsync = 1'b0;
    tick(0, 0, 0, 0, 1, 1);
    end_frame();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
